// File: rtl/ponte_cmd_receiver.sv
// HPS command receiver: toggle-handshake capture of pio_ponte words, opcode decode, show-ahead command queue.
// Latency: a word registered at edge 0 shows on cmd_valid/ponte_status at edge STABLE_CYCLES+2 (empty queue).
// Backpressure: a queueable command waits unacked in DISPATCH while the queue is full; cmd_ready pops the head.
// Optional build macro PONTE_PARITY_EN: odd parity over ponte_word using bit 10, adds sticky parity_err output.

module ponte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                     core_clk,
    input  logic                     arst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    input  logic                     flush,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign head_vld = (level != '0);
    assign head_dat = mem[rd_ptr];
    // push is gated by the registered full flag, so a same-cycle pop never makes room early
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_rdy && head_vld;

    // next occupancy: push and pop together leave the level unchanged, flush empties
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt = level + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    // storage, wrapping pointers and the registered level/full pair
    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    mem[wr_ptr] <= push_dat;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end
endmodule

module ponte_cmd_receiver #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [14:0]                   ponte_word,
    output logic                          ponte_status,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [2:0]                    cmd_opcode,
    output logic [10:0]                   cmd_arg,
    output logic                          cmd_flush,
    output logic                          cmd_illegal,
`ifdef PONTE_PARITY_EN
    output logic                          parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RESET = 3'd5;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [10:0] arg;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        DISPATCH = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  stable_cnt;
    logic [14:0]    word_q;
    logic [14:0]    word_prev;
    logic           parity_ok;
    logic           fifo_push;
    logic           fifo_flush;
    logic           fifo_full;
    cmd_t           push_cmd;
    cmd_t           head_cmd;

    // single input register; word_prev lets SETTLE see whether the word is still moving
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            word_q    <= '0;
            word_prev <= '0;
        end else begin
            word_q    <= ponte_word;
            word_prev <= word_q;
        end
    end

`ifdef PONTE_PARITY_EN
    assign parity_ok       = ^word_q;
    assign push_cmd.arg    = {1'b0, word_q[9:0]};
`else
    assign parity_ok       = 1'b1;
    assign push_cmd.arg    = word_q[10:0];
`endif
    assign push_cmd.opcode = word_q[13:11];

    // queue strobes for the command sitting in DISPATCH
    always_comb begin
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (state == DISPATCH && parity_ok) begin
            if (word_q[13:11] >= 3'd1 && word_q[13:11] <= 3'd4) begin
                fifo_push = !fifo_full;
            end
            if (word_q[13:11] == OP_RESET) begin
                fifo_flush = 1'b1;
            end
        end
    end

    // handshake FSM with registered ack, flush pulse and sticky error flags
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state        <= IDLE;
            stable_cnt   <= '0;
            ponte_status <= 1'b0;
            cmd_flush    <= 1'b0;
            cmd_illegal  <= 1'b0;
`ifdef PONTE_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            cmd_flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (word_q[14] != ponte_status) begin
                        stable_cnt <= CW'(1);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (word_q[14] == ponte_status) begin
                        state <= IDLE;
                    end else if (word_q != word_prev) begin
                        stable_cnt <= CW'(1);
                    end else if (stable_cnt >= CW'(STABLE_CYCLES)) begin
                        state <= DISPATCH;
                    end else begin
                        stable_cnt <= stable_cnt + CW'(1);
                    end
                end
                DISPATCH: begin
                    if (!parity_ok) begin
                        ponte_status <= word_q[14];
                        state        <= IDLE;
`ifdef PONTE_PARITY_EN
                        parity_err   <= 1'b1;
`endif
                    end else begin
                        case (word_q[13:11])
                            OP_NOP: begin
                                ponte_status <= word_q[14];
                                state        <= IDLE;
                            end
                            3'd1, 3'd2, 3'd3, 3'd4: begin
                                // hold without ack until the queue has room
                                if (!fifo_full) begin
                                    ponte_status <= word_q[14];
                                    state        <= IDLE;
                                end
                            end
                            OP_RESET: begin
                                ponte_status <= word_q[14];
                                cmd_flush    <= 1'b1;
                                cmd_illegal  <= 1'b0;
`ifdef PONTE_PARITY_EN
                                parity_err   <= 1'b0;
`endif
                                state        <= IDLE;
                            end
                            default: begin
                                ponte_status <= word_q[14];
                                cmd_illegal  <= 1'b1;
                                state        <= IDLE;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ponte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .core_clk (clk_clk),
        .arst     (reset_reset),
        .push_vld (fifo_push),
        .push_dat (push_cmd),
        .pop_rdy  (cmd_ready),
        .flush    (fifo_flush),
        .head_vld (cmd_valid),
        .head_dat (head_cmd),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign cmd_opcode = head_cmd.opcode;
    assign cmd_arg    = head_cmd.arg;
endmodule

// File: tb/tb_ponte_cmd_receiver.sv
// Bench for ponte_cmd_receiver: directed handshake scenarios plus a randomized command stream.
// Outputs are compared every cycle against a transaction-level model of the queue and ack rules.
// Hand-computed literal checks pin latency, backpressure, illegal/reset/NOP and mid-settle reset.
module tb_ponte_cmd_receiver;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [14:0]   ponte_word = '0;
    logic          cmd_ready = 1'b0;
    logic          ponte_status;
    logic          cmd_valid;
    logic [2:0]    cmd_opcode;
    logic [10:0]   cmd_arg;
    logic          cmd_flush;
    logic          cmd_illegal;
    logic [LW-1:0] fifo_level;
`ifdef PONTE_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    ponte_cmd_receiver #(.FIFO_DEPTH(DEPTH), .STABLE_CYCLES(S)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .ponte_word   (ponte_word),
        .ponte_status (ponte_status),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_arg      (cmd_arg),
        .cmd_flush    (cmd_flush),
        .cmd_illegal  (cmd_illegal),
`ifdef PONTE_PARITY_EN
        .parity_err   (parity_err),
`endif
        .fifo_level   (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    // transaction-level model: pending command becomes due S+2 edges after its word last changed
    bit          m_status = 0, m_illegal = 0, m_flush = 0, m_perr = 0, m_pend = 0;
    logic [14:0] m_prev = '0;
    logic [13:0] m_q[$];
    int          m_edge = 0, m_chg = 0;
    logic [14:0] m_wq;
    bit          m_full, m_push, m_pop, m_fl;

    function automatic bit par_ok(input logic [14:0] w);
`ifdef PONTE_PARITY_EN
        return ^w;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [14:0] mk(input bit t, input logic [2:0] op, input logic [10:0] arg);
        logic [14:0] w;
        w = {t, op, arg};
`ifdef PONTE_PARITY_EN
        w[10] = 1'b0;
        w[10] = ~(^w);
`endif
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_status = 0; m_illegal = 0; m_flush = 0; m_perr = 0; m_pend = 0;
                m_prev = '0; m_edge = 0; m_chg = 0;
                m_q.delete();
            end else begin
                m_edge++;
                m_wq   = m_prev;
                m_full = (m_q.size() == DEPTH);
                m_pop  = cmd_ready && (m_q.size() > 0);
                m_push = 0;
                m_fl   = 0;
                m_flush = 0;
                if (m_pend && m_edge >= m_chg + S + 2) begin
                    if (!par_ok(m_wq)) begin
                        m_status = m_wq[14]; m_perr = 1; m_pend = 0;
                    end else if (m_wq[13:11] == 3'd0) begin
                        m_status = m_wq[14]; m_pend = 0;
                    end else if (m_wq[13:11] <= 3'd4) begin
                        if (!m_full) begin
                            m_push = 1; m_status = m_wq[14]; m_pend = 0;
                        end
                    end else if (m_wq[13:11] == 3'd5) begin
                        m_fl = 1; m_flush = 1; m_illegal = 0; m_perr = 0;
                        m_status = m_wq[14]; m_pend = 0;
                    end else begin
                        m_illegal = 1; m_status = m_wq[14]; m_pend = 0;
                    end
                end
                if (m_fl) begin
                    m_q.delete();
                end else begin
                    if (m_pop) void'(m_q.pop_front());
`ifdef PONTE_PARITY_EN
                    if (m_push) m_q.push_back({m_wq[13:11], 1'b0, m_wq[9:0]});
`else
                    if (m_push) m_q.push_back(m_wq[13:0]);
`endif
                end
                if (m_pend && ponte_word != m_prev) begin
                    m_chg = m_edge;
                end else if (!m_pend && ponte_word[14] != m_status) begin
                    m_pend = 1;
                    m_chg  = m_edge;
                end
                m_prev = ponte_word;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("status", ponte_status, m_status);
                chk("valid", cmd_valid, m_q.size() > 0);
                chk("level", fifo_level, m_q.size());
                chk("illegal", cmd_illegal, m_illegal);
                chk("flush", cmd_flush, m_flush);
`ifdef PONTE_PARITY_EN
                chk("parity_err", parity_err, m_perr);
`endif
                if (m_q.size() > 0) begin
                    chk("opcode", cmd_opcode, m_q[0][13:11]);
                    chk("arg", cmd_arg, m_q[0][10:0]);
                end
            end
        end
    end

    task automatic drive(input logic [14:0] w);
        @(negedge clk);
        ponte_word = w;
    endtask

    task automatic wait_ack(input bit t, input int bound);
        bit got;
        got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (ponte_status === t) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got status %0b expected %0b", ponte_status, t);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [10:0] arg, input int nglitch, input bit corrupt);
        bit t;
        logic [14:0] w;
        t = !m_status;
        for (int g = 0; g < nglitch; g++) drive(mk(t, op, arg ^ 11'(g + 1)));
        w = mk(t, op, arg);
        if (corrupt) w[10] = ~w[10];
        drive(w);
        wait_ack(t, 300);
    endtask

    task automatic pulse_ready(input int n);
        cmd_ready = 1;
        repeat (n) @(negedge clk);
        cmd_ready = 0;
    endtask

    bit          t5;
    bit          rand_on;
    int          r;
    logic [2:0]  rop;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_status", ponte_status, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_opcode", cmd_opcode, 0);
        chk("rst_arg", cmd_arg, 0);
        chk("rst_flush", cmd_flush, 0);
        chk("rst_illegal", cmd_illegal, 0);
        chk("rst_level", fifo_level, 0);
        @(negedge clk);
        rst = 0;

        // first command latency: word at edge 0, ack and head at edge 4
        drive(mk(1, 3'd1, 11'd5));
        repeat (4) @(negedge clk);
        #1;
        chk("lat_valid_e3", cmd_valid, 0);
        chk("lat_status_e3", ponte_status, 0);
        @(negedge clk);
        #1;
        chk("lat_valid_e4", cmd_valid, 1);
        chk("lat_opcode_e4", cmd_opcode, 1);
        chk("lat_arg_e4", cmd_arg, 5);
        chk("lat_status_e4", ponte_status, 1);
        pulse_ready(1);
        #1;
        chk("lat_pop_level", fifo_level, 0);

        // glitching word: only the settled value is queued
        drive(mk(0, 3'd1, 11'd5));
        drive(mk(0, 3'd1, 11'd7));
        wait_ack(0, 30);
        chk("glitch_level", fifo_level, 1);
        chk("glitch_arg", cmd_arg, 7);
        pulse_ready(1);

        // backpressure: four fill the queue, the fifth waits without ack
        for (int i = 0; i < 4; i++) send(3'(1 + i), 11'(16 + i), 0, 0);
        chk("bp_level4", fifo_level, 4);
        t5 = !m_status;
        drive(mk(t5, 3'd2, 11'd99));
        repeat (10) @(negedge clk);
        #1;
        chk("bp_no_ack", ponte_status, !t5);
        chk("bp_level_hold", fifo_level, 4);
        pulse_ready(1);
        wait_ack(t5, 20);
        chk("bp_level_after", fifo_level, 4);
        pulse_ready(6);
        #1;
        chk("bp_drained", fifo_level, 0);

        // illegal opcode then RESET
        send(3'd1, 11'd33, 0, 0);
        send(3'd6, 11'd0, 0, 0);
        chk("ill_flag", cmd_illegal, 1);
        chk("ill_no_entry", fifo_level, 1);
        send(3'd5, 11'd0, 0, 0);
        chk("rst_cmd_flush", cmd_flush, 1);
        chk("rst_cmd_illegal", cmd_illegal, 0);
        chk("rst_cmd_level", fifo_level, 0);
        @(negedge clk);
        #1;
        chk("rst_cmd_flush_once", cmd_flush, 0);

        // NOP acks without touching the queue
        send(3'd1, 11'd44, 0, 0);
        t5 = !m_status;
        send(3'd0, 11'd0, 0, 0);
        chk("nop_status", ponte_status, t5);
        chk("nop_level", fifo_level, 1);
        chk("nop_valid", cmd_valid, 1);

        // reset mid-settle discards the queue; a held toggle=1 word is then a new command
        if (m_status) send(3'd0, 11'd0, 0, 0);
        drive(mk(1, 3'd3, 11'd9));
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_status", ponte_status, 0);
        rst = 0;
        wait_ack(1, 30);
        chk("mid_rst_level_after", fifo_level, 1);
        chk("mid_rst_opcode", cmd_opcode, 3);
        chk("mid_rst_arg", cmd_arg, 9);
        pulse_ready(3);

`ifdef PONTE_PARITY_EN
        // corrupted parity: acked, flagged, not queued
        send(3'd1, 11'd5, 0, 1);
        chk("par_err", parity_err, 1);
        chk("par_level", fifo_level, 0);
        send(3'd1, 11'd5, 0, 0);
        chk("par_ok_level", fifo_level, 1);
        pulse_ready(3);
`endif

        // randomized stream with random consumer readiness
        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    @(negedge clk);
                    cmd_ready = ($urandom_range(0, 2) != 0);
                end
                cmd_ready = 0;
            end
            begin
                for (int n = 0; n < 250; n++) begin
                    r = $urandom_range(0, 15);
                    if (r < 10)       rop = 3'(1 + r % 4);
                    else if (r < 12)  rop = 3'd0;
                    else if (r == 12) rop = 3'd5;
                    else if (r < 15)  rop = 3'd6;
                    else              rop = 3'd7;
`ifdef PONTE_PARITY_EN
                    send(rop, 11'($urandom_range(0, 2047)), $urandom_range(0, 2), ($urandom_range(0, 11) == 0));
`else
                    send(rop, 11'($urandom_range(0, 2047)), $urandom_range(0, 2), 0);
`endif
                end
                rand_on = 0;
            end
        join
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ponte_cmd_receiver.md
Name: ponte_cmd_receiver

Overview:
- Consumes the 15-bit command word the HPS drives onto the pio_ponte bridge and produces the 1-bit status the HPS reads back on pio_status.
- Detects each new command with a toggle handshake and filters words that are still changing.
- Decodes the opcode, queues legal commands in a small show-ahead FIFO and presents them to the zoom coprocessor core over a valid/ready interface.
- Sits between the soc_system PIO exports and the coprocessor datapath.

Parameters:
- FIFO_DEPTH, 4: command queue entries; power of two, minimum 2.
- STABLE_CYCLES, 2: consecutive identical samples required before a word is accepted; minimum 1.

Ports:
- clk_clk  in  1  system clock (same clock as the PIO).
- reset_reset  in  1  asynchronous, active-high reset.
- ponte_word  in  15  from pio_ponte. [14] = toggle, [13:11] = opcode, [10:0] = argument.
- ponte_status  out  1  to pio_status; ack toggle, equal to [14] of the last accepted word.
- cmd_valid  out  1  FIFO head valid.
- cmd_ready  in  1  coprocessor accepts the head.
- cmd_opcode  out  3  head opcode.
- cmd_arg  out  11  head argument.
- cmd_flush  out  1  one-cycle pulse on an accepted RESET command.
- cmd_illegal  out  1  sticky illegal-opcode flag.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset values (async, active-high): ponte_status=0, cmd_valid=0, cmd_opcode=0, cmd_arg=0, cmd_flush=0, cmd_illegal=0, fifo_level=0, FSM=IDLE, input register=0.
- Input: ponte_word is registered once into word_q. All decisions use word_q.
- FSM state IDLE: when word_q[14] != ponte_status, load stable_cnt=1 and go to SETTLE.
- FSM state SETTLE:
  - If word_q differs from its previous value, reset stable_cnt to 1.
  - When stable_cnt reaches STABLE_CYCLES, go to DISPATCH.
  - If word_q[14] returns to equal ponte_status, go back to IDLE (the HPS withdrew the word).
- FSM state DISPATCH, opcode actions (all paths then return to IDLE):
  - 0 NOP: ack only.
  - 1 ZOOM_IN_NN, 2 ZOOM_IN_REP, 3 ZOOM_OUT_DEC, 4 ZOOM_OUT_AVG: if FIFO not full, write {opcode,arg} and set ponte_status <= word_q[14]. If full, hold in DISPATCH with no ack (backpressure).
  - 5 RESET: flush FIFO, clear cmd_illegal, pulse cmd_flush, ack. The FIFO does not need to be non-full.
  - 6, 7: set cmd_illegal, ack, no write.
- Latency: with an empty FIFO and STABLE_CYCLES=2, a word change at edge 0 produces cmd_valid=1 and the flipped ponte_status at edge 4. In general the update lands at edge STABLE_CYCLES+2.
- FIFO:
  - Show-ahead; cmd_valid = not empty; head fields are driven directly.
  - Pop on cmd_valid&&cmd_ready.
  - Push is gated by the registered full flag.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The RESET flush overrides a same-cycle pop.
- cmd_flush and the flush take effect in the same cycle as the ack.
- Reset mid-SETTLE or mid-DISPATCH discards the pending word. After reset, any word whose [14]=1 is treated as a new command.

Optional Feature:
- Macro PONTE_PARITY_EN.
- Defined:
  - ponte_word[10] is a parity bit chosen so that the XOR of bits [14:0] is 1 (odd parity); cmd_arg[10] is driven 0.
  - A word failing parity in DISPATCH is acked, never queued, and sets output parity_err (sticky, 1 bit, cleared by reset or an accepted RESET).
- Undefined: the parity_err port is absent and all 11 argument bits are passed through.

Test Plan:
- After reset, ponte_word=15'h4805 (toggle 1, op1, arg 5) held. At edge 4: cmd_valid=1, cmd_opcode=1, cmd_arg=5, ponte_status=1. cmd_ready=1 then pops and fifo_level returns to 0.
- Word glitch: apply 15'h4805, change to 15'h4807 after 1 cycle, then hold. Exactly one entry is queued, with arg=7.
- Backpressure with FIFO_DEPTH=4 and cmd_ready=0: send 5 commands (alternating toggle, each after ack). fifo_level=4, the 5th stays unacked (ponte_status unchanged). Raising cmd_ready for one cycle acks and queues the 5th with level back at 4.
- Opcode 6 (15'h3000 with toggle 0 after a prior ack of 1): cmd_illegal=1, no queue entry, status=0. A following RESET (op5) clears cmd_illegal, pulses cmd_flush once and sets fifo_level=0.
- NOP (op0): status toggles, fifo_level and cmd_valid unchanged.
- With PONTE_PARITY_EN, send 15'h4805 with a wrong parity bit: ack toggles, parity_err=1, no entry queued. A correct word then queues normally.
